// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state, bundled
// stage control bits and the hazard-detection helper.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } hazard_state_t;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_FREEZE = '0;
  localparam pipe_ctrl_t CTRL_ADVANCE = '{
    load_pc: 1'b1, load_if_id: 1'b1, load_id_ex: 1'b1, load_ex_mem: 1'b1,
    load_mem_wb: 1'b1, flush_if_id: 1'b0, flush_id_ex: 1'b0, flush_ex_mem: 1'b0
  };

  function automatic logic src_hit(input logic [4:0] rd, input logic [4:0] rs,
                                   input logic uses);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the hazard sequencer (master) and the datapath it steers (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  import pipeline_hazard_ctrl_pkg::*;

  // Request/response: imem_read is held high until the cycle imem_resp is 1,
  // dmem_access is held high until the cycle dmem_resp is 1; a request with its
  // response in the same cycle completes without stalling.
  logic            imem_read;
  logic            imem_resp;
  logic            dmem_access;
  logic            dmem_resp;
  logic            ex_is_load;
  logic [4:0]      ex_rd;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic            br_mispredict;
  logic [XLEN-1:0] br_target;

  logic             load_pc;
  logic             load_if_id;
  logic             load_id_ex;
  logic             load_ex_mem;
  logic             load_mem_wb;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic             pc_redirect;
  logic [XLEN-1:0]  redirect_addr;
  logic [CNT_W-1:0] istall_cnt;
  logic [CNT_W-1:0] dstall_cnt;
  logic [CNT_W-1:0] lu_stall_cnt;
  hazard_state_t    dbg_state;

  modport master (
    input  imem_read, imem_resp, dmem_access, dmem_resp, ex_is_load, ex_rd,
           id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, br_mispredict, br_target,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect, redirect_addr,
           istall_cnt, dstall_cnt, lu_stall_cnt, dbg_state
  );

  modport slave (
    output imem_read, imem_resp, dmem_access, dmem_resp, ex_is_load, ex_rd,
           id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, br_mispredict, br_target,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect, redirect_addr,
           istall_cnt, dstall_cnt, lu_stall_cnt, dbg_state
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_counters.sv
// Three free-running stall counters; each wraps modulo 2^CNT_W.
module pipeline_hazard_ctrl_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_istall,
  input  logic             inc_dstall,
  input  logic             inc_lu,
  output logic [CNT_W-1:0] istall_cnt,
  output logic [CNT_W-1:0] dstall_cnt,
  output logic [CNT_W-1:0] lu_stall_cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      istall_cnt   <= '0;
      dstall_cnt   <= '0;
      lu_stall_cnt <= '0;
    end else begin
      if (inc_istall) istall_cnt   <= istall_cnt + ONE;
      if (inc_dstall) dstall_cnt   <= dstall_cnt + ONE;
      if (inc_lu)     lu_stall_cnt <= lu_stall_cnt + ONE;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves cache misses,
// load-use hazards and mispredicts, parking a redirect behind an open fetch.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int XLEN  = 32
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.master hz
);

  hazard_state_t   state_q, state_d;
  logic [XLEN-1:0] target_q, target_d;
  pipe_ctrl_t      ctrl;
  logic            pc_redirect;
  logic            dstall, istall, luse, mp;
  logic            inc_lu, inc_istall;

  always_comb begin
    dstall = hz.dmem_access & ~hz.dmem_resp;
    istall = hz.imem_read & ~hz.imem_resp;
    luse   = hz.ex_is_load && (hz.ex_rd != 5'd0) &&
             (src_hit(hz.ex_rd, hz.id_rs1, hz.id_uses_rs1) ||
              src_hit(hz.ex_rd, hz.id_rs2, hz.id_uses_rs2));
    // EX only retires the branch when the back end is moving.
    mp     = hz.br_mispredict & ~dstall;
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    ctrl        = CTRL_ADVANCE;
    pc_redirect = 1'b0;
    inc_lu      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (dstall) begin
          ctrl = CTRL_FREEZE;
        end else if (mp && istall) begin
          state_d          = SQUASH;
          target_d         = hz.br_target;
          ctrl.load_pc     = 1'b0;
          ctrl.flush_if_id = 1'b1;
          ctrl.flush_id_ex = 1'b1;
        end else if (mp) begin
          pc_redirect      = 1'b1;
          ctrl.flush_if_id = 1'b1;
          ctrl.flush_id_ex = 1'b1;
        end else if (istall) begin
          ctrl.load_pc     = 1'b0;
          ctrl.load_if_id  = 1'b0;
          ctrl.flush_if_id = 1'b1;
        end else if (luse) begin
          ctrl.load_pc     = 1'b0;
          ctrl.load_if_id  = 1'b0;
          ctrl.flush_id_ex = 1'b1;
          inc_lu           = 1'b1;
        end
      end
      SQUASH: begin
        // The fetch returning here is the wrong-path instruction: bubble it.
        ctrl.load_if_id  = 1'b0;
        ctrl.flush_if_id = 1'b1;
        if (dstall) begin
          ctrl = CTRL_FREEZE;
        end else if (hz.imem_resp) begin
          pc_redirect = 1'b1;
          state_d     = RUN;
        end else begin
          ctrl.load_pc = 1'b0;
        end
      end
    endcase
    if (!rst) begin
      ctrl        = CTRL_FREEZE;
      pc_redirect = 1'b0;
    end
  end

  assign inc_istall = istall | ((state_q == SQUASH) & ~ctrl.load_pc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  pipeline_hazard_ctrl_counters #(.CNT_W(CNT_W)) u_counters (
    .clk          (clk),
    .rst          (rst),
    .inc_istall   (inc_istall),
    .inc_dstall   (dstall),
    .inc_lu       (inc_lu),
    .istall_cnt   (hz.istall_cnt),
    .dstall_cnt   (hz.dstall_cnt),
    .lu_stall_cnt (hz.lu_stall_cnt)
  );

  assign hz.load_pc       = ctrl.load_pc;
  assign hz.load_if_id    = ctrl.load_if_id;
  assign hz.load_id_ex    = ctrl.load_id_ex;
  assign hz.load_ex_mem   = ctrl.load_ex_mem;
  assign hz.load_mem_wb   = ctrl.load_mem_wb;
  assign hz.flush_if_id   = ctrl.flush_if_id;
  assign hz.flush_id_ex   = ctrl.flush_id_ex;
  assign hz.flush_ex_mem  = ctrl.flush_ex_mem;
  assign hz.pc_redirect   = pc_redirect;
  assign hz.redirect_addr = (state_q == SQUASH) ? target_q : hz.br_target;
  assign hz.dbg_state     = state_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Drives the load and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves instruction-cache misses, data-cache misses, load-use hazards and EX-stage branch mispredicts.
- Holds a redirect when a mispredict arrives during an outstanding fetch; maintains stall performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.
- XLEN, 32, width of the redirect target.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- imem_read  in  1  fetch request, held high until imem_resp
- imem_resp  in  1  fetch data valid this cycle
- dmem_access  in  1  MEM stage read or write request, held until dmem_resp
- dmem_resp  in  1  data access complete this cycle
- ex_is_load  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of EX instruction
- id_rs1, id_rs2  in  5 each  source registers of ID instruction
- id_uses_rs1, id_uses_rs2  in  1 each  source register actually read
- br_mispredict  in  1  EX resolved a mispredicted control transfer
- br_target  in  XLEN  correct PC for br_mispredict
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register enables
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  synchronous clear (bubble insert)
- pc_redirect  out  1  PC must take redirect_addr this cycle
- redirect_addr  out  XLEN  redirect target
- istall_cnt, dstall_cnt, lu_stall_cnt  out  CNT_W each  stall cycle counters

Behaviour:
- Stall terms (combinational):
  - dstall = dmem_access & ~dmem_resp
  - istall = imem_read & ~imem_resp
  - luse = ex_is_load & ex_rd != 0 & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))
  - mp = br_mispredict & ~dstall; a mispredict is honoured only when EX advances.
- FSM states: RUN, SQUASH.
- Priority in RUN, highest first:
  1. dstall: every load and every flush is 0; whole pipe frozen.
  2. mp & istall: go to SQUASH; capture br_target into redirect register; flush_id_ex=1, flush_if_id=1; load_pc=0; back stages load.
  3. mp: pc_redirect=1, redirect_addr=br_target, load_pc=1; flush_if_id=1, flush_id_ex=1; all loads 1.
  4. istall: load_pc=0, load_if_id=0, flush_if_id=1 (bubble, older work drains); ID/EX, EX/MEM, MEM/WB load.
  5. luse: load_pc=0, load_if_id=0, flush_id_ex=1; EX/MEM and MEM/WB load.
  6. Otherwise: all loads 1, all flushes 0.
- SQUASH:
  - load_pc=0 and flush_if_id=1 until imem_resp; returned instruction is discarded.
  - Cycle with imem_resp and ~dstall: pc_redirect=1, redirect_addr=captured target, load_pc=1, then go to RUN.
  - dstall in SQUASH: freeze as in RUN case 1 and stay in SQUASH.
  - Further br_mispredict in SQUASH is impossible (EX holds a bubble); ignore it.
- flush_ex_mem is reserved for exceptions and is tied 0 in this revision.
- redirect_addr equals the captured register in SQUASH and br_target in RUN.
- Counters:
  - istall_cnt increments each cycle istall or SQUASH holds the PC.
  - dstall_cnt increments each dstall cycle.
  - lu_stall_cnt increments each cycle case 5 applies.
  - All counters wrap modulo 2^CNT_W.
- Reset: rst low, asynchronously → state RUN, redirect register 0, counters 0; all load, flush and pc_redirect outputs forced 0 while rst is low. Reset during SQUASH discards the pending redirect.
- Latency: all control outputs are combinational from state and inputs in the same cycle; no extra pipeline delay.

Decomposition:
- rv32i_types package: enum hazard_state_t {RUN, SQUASH}; struct pipe_ctrl_t bundling the stage load/flush bits.
- Natural sub-module: hazard_stall_counters (three saturating-free wrap counters with enables).

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → load_pc=0, load_if_id=0, flush_id_ex=1, lu_stall_cnt +1; ex_rd=0 → no stall.
- D-miss: dmem_access=1 for 4 cycles, dmem_resp on 4th → 3 cycles of all loads 0, dstall_cnt=3, full advance on cycle 4.
- Mispredict, no miss: br_mispredict=1, br_target=0x60 → pc_redirect=1, redirect_addr=0x60, flush_if_id=flush_id_ex=1 in the same cycle.
- Mispredict during I-miss: imem_read=1, imem_resp=0, br_mispredict, target 0x80; imem_resp 3 cycles later → SQUASH for 3 cycles, redirect to 0x80 on the resp cycle, back to RUN.
- Mispredict during D-miss: br_mispredict & dstall → no redirect until dmem_resp cycle, then redirect fires.
- Async reset asserted mid-SQUASH, off clock edge → outputs 0 immediately, counters 0, state RUN after release, no redirect issued.
